mtr_drv_ctrl: RTL
=================

Name: mtr_drv_ctrl

Overview:
Motor-drive controller that sequences the duty inputs of the two 11-bit PWM generators (left/right wheel).
- Converts signed speed commands into an 11-bit duty plus a direction bit per wheel.
- Applies deadband offset and per-period slew limiting.
- Enforces ramp-to-zero before any direction reversal.
- Forces both duties to 0 on over-current via a fault FSM.
- Sits between the balance-control math and the PWM/H-bridge stage; duties change only on PWM period boundaries, except on fault.

Parameters:
MIN_DUTY, 11'h080, deadband offset added to any nonzero speed magnitude
SLEW_STEP, 11'd32, max duty change per PWM period (must be >0)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  drive enable; low drives duties to 0 via ramp
cmd_vld  in  1  one-cycle strobe; captures lft_spd/rght_spd
lft_spd  in  12  signed left speed command
rght_spd  in  12  signed right speed command
ovr_i  in  1  over-current flag from bridge, level
clr_flt  in  1  one-cycle fault clear request
lft_duty  out  11  duty to left PWM
rght_duty  out  11  duty to right PWM
lft_rev  out  1  left direction, 1 = reverse
rght_rev  out  1  right direction
period_tick  out  1  high when internal period count == 2047
fault  out  1  high in FAULT state

Behaviour:
- Reset (rst=1 at clk edge):
  - Period count, command registers, all outputs = 0.
  - State = IDLE.
  - rst wins over every other input, mid-ramp or mid-fault.
- Period counter: 11-bit free-running, wraps 2047->0, runs in all states. It is aligned with the PWM counters because both are released from reset on the same edge.
- period_tick: combinational decode of count==2047.
- Duty/rev registers load only on edges where period_tick=1. The new duty is therefore visible when the PWM count is 0.
- Command capture: on cmd_vld, store lft_spd/rght_spd. No backpressure; a later strobe overwrites. Until the next tick, only the stored value matters.
- Target per wheel:
  - mag = |spd|; -2048 saturates to 2047.
  - tgt = 0 if spd==0 or state!=RUN.
  - Otherwise tgt = min(mag+MIN_DUTY, 2047). Use a 12-bit sum, then saturate.
  - Desired dir = spd[11].
- Reversal: if desired dir != current rev and current duty != 0, the effective target is 0. When duty==0 at a tick, rev takes the desired dir on that tick; duty stays 0 that tick and ramps from the next tick.
- Slew at tick:
  - If |tgt-duty| <= SLEW_STEP, duty = tgt.
  - Otherwise duty moves toward tgt by exactly SLEW_STEP.
  - No underflow below 0 or overflow above 2047.
- FSM:
  - IDLE -> RUN when en=1 and fault cleared.
  - RUN -> IDLE when en=0. Duties ramp down in IDLE at SLEW_STEP per tick; rev holds.
  - RUN or IDLE -> FAULT on any cycle with ovr_i=1. On the next edge, duties are forced to 0 immediately, without waiting for a tick; rev holds.
  - FAULT: duties held 0, commands ignored.
  - FAULT -> IDLE only on an edge with clr_flt=1 and ovr_i=0. clr_flt while ovr_i=1 is ignored.
  - If ovr_i and a tick occur on the same edge, the fault wins.
- fault = (state==FAULT), registered.

Decomposition:
Shared package mtr_pkg holds:
- state typedef enum {IDLE, RUN, FAULT}
- DUTY_W=11, SPD_W=12, DUTY_MAX=11'h7FF
One sub-module, mtr_chan, is instantiated twice and contains:
- stored speed
- target computation
- reversal interlock
- slew register

mtr_chan inputs: tick, run, force_zero. Outputs: duty, rev. The FSM and period counter live in the top level.

Test Plan:
- Reset, then en=1, cmd lft_spd=+400 -> lft_duty steps 0,32,64,…, reaching exactly 528 (400+128) at ticks spaced 2048 clocks; rev=0; duty constant between ticks.
- lft_spd=0 after settled at 528 -> ramps to 0 in 17 ticks (last step 16); never negative.
- Settled at +528, cmd -300 -> ramps to 0, rev flips to 1 on the tick duty==0 while duty stays 0, then ramps to 428; lft_rev never changes while duty!=0.
- lft_spd=-2048 and rght_spd=+2047 -> both duties saturate at 2047, rev=1 and 0 respectively.
- ovr_i pulse mid-period at duty 500 -> next edge duties=0, fault=1; clr_flt with ovr_i=1 ignored; clr_flt with ovr_i=0 -> IDLE, then RUN ramps from 0.
- rst asserted mid-ramp and during FAULT -> next edge all outputs 0, state IDLE, period count restarts at 0 (period_tick 2047 cycles later).

Source files
------------

// File: rtl/mtr_drv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtr_pkg
// Brief    : Shared types, widths and helpers for the motor-drive controller.
// Revision : 1.0 - initial release
// ============================================================================
package mtr_pkg;

    localparam int DUTY_W = 11;
    localparam int SPD_W  = 12;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Magnitude of a signed speed; the one unrepresentable value (-2048)
    // saturates to the largest duty so it never wraps to zero.
    function automatic logic [DUTY_W-1:0] spd_mag(input logic [SPD_W-1:0] spd);
        logic [SPD_W-1:0] v_abs;
        v_abs = spd[SPD_W-1] ? (~spd + 1'b1) : spd;
        if (v_abs[SPD_W-1]) begin
            return DUTY_MAX;
        end
        return v_abs[DUTY_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_drv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_ctrl_if
// Brief    : Command/status bundle between balance math and motor controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mtr_drv_ctrl_if;
    import mtr_pkg::*;

    logic              en;
    logic              cmd_vld;
    logic [SPD_W-1:0]  lft_spd;
    logic [SPD_W-1:0]  rght_spd;
    logic              ovr_i;
    logic              clr_flt;
    logic [DUTY_W-1:0] lft_duty;
    logic [DUTY_W-1:0] rght_duty;
    logic              lft_rev;
    logic              rght_rev;
    logic              period_tick;
    logic              fault;

    // Controller side (drives commands, observes drive outputs)
    modport master (
        output en, cmd_vld, lft_spd, rght_spd, ovr_i, clr_flt,
        input  lft_duty, rght_duty, lft_rev, rght_rev, period_tick, fault
    );

    // Motor-drive side
    modport slave (
        input  en, cmd_vld, lft_spd, rght_spd, ovr_i, clr_flt,
        output lft_duty, rght_duty, lft_rev, rght_rev, period_tick, fault
    );

endinterface
`default_nettype wire

// File: rtl/mtr_drv_ctrl_chan.sv
`default_nettype none
// ============================================================================
// Module   : mtr_chan
// Brief    : One wheel: stored speed, target, reversal interlock, slew reg.
// Revision : 1.0 - initial release
// ============================================================================
module mtr_chan
    import mtr_pkg::*;
#(
    parameter logic [DUTY_W-1:0] MIN_DUTY  = 11'h080,
    parameter logic [DUTY_W-1:0] SLEW_STEP = 11'd32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              tick,
    input  wire logic              run,
    input  wire logic              force_zero,
    input  wire logic              cap,
    input  wire logic [SPD_W-1:0]  spd_in,
    output logic      [DUTY_W-1:0] duty,
    output logic                   rev
);

    logic [SPD_W-1:0]  r_spd;
    logic [DUTY_W-1:0] r_duty;
    logic              r_rev;

    logic [DUTY_W-1:0] w_mag;
    logic [SPD_W-1:0]  w_sum;
    logic [DUTY_W-1:0] w_tgt;
    logic [DUTY_W-1:0] w_eff_tgt;
    logic [DUTY_W-1:0] w_diff;
    logic [DUTY_W-1:0] w_next_duty;
    logic              w_dir;
    logic              w_flip;

    // Target, reversal interlock and slew-limited next duty
    always_comb begin
        w_mag  = spd_mag(r_spd);
        w_sum  = {1'b0, w_mag} + {1'b0, MIN_DUTY};
        w_dir  = r_spd[SPD_W-1];
        w_tgt  = '0;
        if (run && (r_spd != '0)) begin
            w_tgt = w_sum[SPD_W-1] ? DUTY_MAX : w_sum[DUTY_W-1:0];
        end
        // Direction can only change once the bridge is fully off
        w_flip    = run && (w_dir != r_rev);
        w_eff_tgt = w_flip ? '0 : w_tgt;
        w_diff    = '0;
        w_next_duty = r_duty;
        if (w_eff_tgt >= r_duty) begin
            w_diff      = w_eff_tgt - r_duty;
            w_next_duty = (w_diff <= SLEW_STEP) ? w_eff_tgt : r_duty + SLEW_STEP;
        end else begin
            w_diff      = r_duty - w_eff_tgt;
            w_next_duty = (w_diff <= SLEW_STEP) ? w_eff_tgt : r_duty - SLEW_STEP;
        end
    end

    // Command capture anytime; duty/rev update on period boundary or fault
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spd  <= '0;
            r_duty <= '0;
            r_rev  <= 1'b0;
        end else begin
            if (cap) begin
                r_spd <= spd_in;
            end
            if (force_zero) begin
                r_duty <= '0;
            end else if (tick) begin
                r_duty <= w_next_duty;
                if (w_flip && (r_duty == '0)) begin
                    r_rev <= w_dir;
                end
            end
        end
    end

    assign duty = r_duty;
    assign rev  = r_rev;

endmodule
`default_nettype wire

// File: rtl/mtr_drv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mtr_drv_ctrl
// Brief    : Two-wheel PWM duty sequencer with slew, interlock, fault FSM.
// Revision : 1.0 - initial release
// ============================================================================
module mtr_drv_ctrl
    import mtr_pkg::*;
#(
    parameter logic [DUTY_W-1:0] MIN_DUTY  = 11'h080,
    parameter logic [DUTY_W-1:0] SLEW_STEP = 11'd32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mtr_drv_ctrl_if.slave bus
);

    logic [DUTY_W-1:0] r_cnt;
    state_t            r_state;
    logic              r_fault;

    logic              w_tick;
    logic              w_run;
    logic              w_force_zero;
    logic              w_cap;
    logic [DUTY_W-1:0] w_lft_duty;
    logic [DUTY_W-1:0] w_rght_duty;
    logic              w_lft_rev;
    logic              w_rght_rev;

    assign w_tick       = (r_cnt == DUTY_MAX);
    assign w_run        = (r_state == RUN);
    // Over-current zeroes the bridge on the very edge it is seen
    assign w_force_zero = bus.ovr_i || (r_state == FAULT);
    assign w_cap        = bus.cmd_vld && (r_state != FAULT);

    // Free-running period counter, in lockstep with the PWM counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Drive state machine with registered fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ovr_i) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else if (bus.en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.ovr_i) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else if (!bus.en) begin
                        r_state <= IDLE;
                    end
                end
                FAULT: begin
                    if (bus.clr_flt && !bus.ovr_i) begin
                        r_state <= IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    mtr_chan #(.MIN_DUTY(MIN_DUTY), .SLEW_STEP(SLEW_STEP)) u_lft (
        .clk        (clk),
        .rst        (rst),
        .tick       (w_tick),
        .run        (w_run),
        .force_zero (w_force_zero),
        .cap        (w_cap),
        .spd_in     (bus.lft_spd),
        .duty       (w_lft_duty),
        .rev        (w_lft_rev)
    );

    mtr_chan #(.MIN_DUTY(MIN_DUTY), .SLEW_STEP(SLEW_STEP)) u_rght (
        .clk        (clk),
        .rst        (rst),
        .tick       (w_tick),
        .run        (w_run),
        .force_zero (w_force_zero),
        .cap        (w_cap),
        .spd_in     (bus.rght_spd),
        .duty       (w_rght_duty),
        .rev        (w_rght_rev)
    );

    assign bus.lft_duty    = w_lft_duty;
    assign bus.rght_duty   = w_rght_duty;
    assign bus.lft_rev     = w_lft_rev;
    assign bus.rght_rev    = w_rght_rev;
    assign bus.period_tick = w_tick;
    assign bus.fault       = r_fault;

endmodule
`default_nettype wire
